// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the EX/MEM stage (master) and data_memory_ctrl (slave).
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        addr_err;

  modport master (
    output req_valid, opcode, MemRead, MemWrite, address, write_data,
    input  req_ready, resp_valid, read_data, addr_err
  );

  modport slave (
    input  req_valid, opcode, MemRead, MemWrite, address, write_data,
    output req_ready, resp_valid, read_data, addr_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Clocked byte-addressed little-endian MIPS data memory with latency-programmable handshake.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned halfword/word accesses as addr_err.
module data_memory_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  data_memory_ctrl_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [5:0]  op_reg;
  logic        rd_reg;
  logic        wr_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        req_ready_reg;
  logic        resp_valid_reg;
  logic        addr_err_reg;
  logic [31:0] read_data_reg;

  logic [31:0] mem [DEPTH];

  logic          in_idle, accept, enter_resp, commit;
  logic [5:0]    cur_op;
  logic          cur_rd, cur_wr;
  logic [31:0]   cur_addr, cur_wdata;
  logic [AW-1:0] cur_idx;
  logic          is_sb, is_sh, is_lb, is_lbu, is_lh, is_lhu;
  logic          range_err, ctrl_err, align_err, err;
  logic [3:0]    be;
  logic [31:0]   wlane, word, load_val;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign in_idle    = (state_reg == IDLE);
  assign accept     = in_idle && bus.req_valid && req_ready_reg;
  assign enter_resp = (accept && (LATENCY == 1)) || ((state_reg == WAIT) && (cnt_reg == 4'd1));

  // With LATENCY=1 the access completes on the accept edge, so decode the live inputs then.
  assign cur_op    = in_idle ? bus.opcode     : op_reg;
  assign cur_rd    = in_idle ? bus.MemRead    : rd_reg;
  assign cur_wr    = in_idle ? bus.MemWrite   : wr_reg;
  assign cur_addr  = in_idle ? bus.address    : addr_reg;
  assign cur_wdata = in_idle ? bus.write_data : wdata_reg;
  assign cur_idx   = cur_addr[AW+1:2];

  assign is_sb  = cur_wr && (cur_op == 6'h28);
  assign is_sh  = cur_wr && (cur_op == 6'h29);
  assign is_lb  = cur_rd && (cur_op == 6'h20);
  assign is_lbu = cur_rd && (cur_op == 6'h24);
  assign is_lh  = cur_rd && (cur_op == 6'h21);
  assign is_lhu = cur_rd && (cur_op == 6'h25);

  assign range_err = |cur_addr[31:AW+2];
  assign ctrl_err  = cur_rd && cur_wr;
`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = (is_sh || is_lh || is_lhu) ? cur_addr[0]
                   : (!(is_sb || is_lb || is_lbu) && (cur_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif
  assign err    = (cur_rd || cur_wr) && (range_err || ctrl_err || align_err);
  assign commit = enter_resp && cur_wr && !err && !reset;

  always_comb begin
    be    = 4'b1111;
    wlane = cur_wdata;
    if (is_sb) begin
      be    = 4'b0001 << cur_addr[1:0];
      wlane = {4{cur_wdata[7:0]}};
    end else if (is_sh) begin
      be    = cur_addr[1] ? 4'b1100 : 4'b0011;
      wlane = {2{cur_wdata[15:0]}};
    end
  end

  always_comb begin
    word = mem[cur_idx];
    case (cur_addr[1:0])
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = cur_addr[1] ? word[31:16] : word[15:0];
    load_val = word;
    if (is_lb)       load_val = {{24{byte_sel[7]}}, byte_sel};
    else if (is_lbu) load_val = {24'd0, byte_sel};
    else if (is_lh)  load_val = {{16{half_sel[15]}}, half_sel};
    else if (is_lhu) load_val = {16'd0, half_sel};
    if (err || !cur_rd) load_val = '0;
  end

  // Byte-lane write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[cur_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      op_reg         <= '0;
      rd_reg         <= 1'b0;
      wr_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      read_data_reg  <= '0;
      addr_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          req_ready_reg <= 1'b1;
          if (accept) begin
            op_reg        <= bus.opcode;
            rd_reg        <= bus.MemRead;
            wr_reg        <= bus.MemWrite;
            addr_reg      <= bus.address;
            wdata_reg     <= bus.write_data;
            cnt_reg       <= CNT_LOAD;
            req_ready_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: cnt_reg <= cnt_reg - 4'd1;
        default: begin
          state_reg      <= IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b0;
          read_data_reg  <= '0;
          addr_err_reg   <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        state_reg      <= RESP;
        resp_valid_reg <= 1'b1;
        read_data_reg  <= load_val;
        addr_err_reg   <= err;
      end
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.read_data  = read_data_reg;
  assign bus.addr_err   = addr_err_reg;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: table of load/store vectors at LATENCY=1,
// plus hand sequences for LATENCY=4 handshake timing and LATENCY=3 reset mid-operation.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, rst4;

  data_memory_ctrl_if if1();
  data_memory_ctrl_if if3();
  data_memory_ctrl_if if4();

  data_memory_ctrl #(.DEPTH(256), .LATENCY(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(if1));
  data_memory_ctrl #(.DEPTH(256), .LATENCY(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(if3));
  data_memory_ctrl #(.DEPTH(256), .LATENCY(4)) u_dut4 (.clk(clk), .reset(rst4), .bus(if4));

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic [5:0] op, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e);
    vec_t v;
    v.name = name; v.op = op; v.rd = rd; v.wr = wr;
    v.addr = addr; v.wd = wd; v.exp_d = exp_d; v.exp_e = exp_e;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One request on the LATENCY=1 instance; lat counts negedges from accept to resp_valid.
  task automatic xact1(input logic [5:0] op, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!if1.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if1.req_valid  = 1'b1;
    if1.opcode     = op;
    if1.MemRead    = rd;
    if1.MemWrite   = wr;
    if1.address    = a;
    if1.write_data = wd;
    @(posedge clk);
    #1;
    if1.req_valid  = 1'b0;
    if1.opcode     = 6'h2B;
    if1.MemRead    = 1'b1;
    if1.MemWrite   = 1'b1;
    if1.address    = 32'hFFFF_FFFF;
    if1.write_data = 32'h5A5A_5A5A;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if1.resp_valid && lat < 50);
    rdata = if1.read_data;
    err   = if1.addr_err;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n;
    logic        saw;

    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    if1.req_valid = 1'b0; if1.opcode = '0; if1.MemRead = 1'b0; if1.MemWrite = 1'b0;
    if1.address = '0; if1.write_data = '0;
    if3.req_valid = 1'b0; if3.opcode = '0; if3.MemRead = 1'b0; if3.MemWrite = 1'b0;
    if3.address = '0; if3.write_data = '0;
    if4.req_valid = 1'b0; if4.opcode = '0; if4.MemRead = 1'b0; if4.MemWrite = 1'b0;
    if4.address = '0; if4.write_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, if1.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, if1.resp_valid}, 32'd0);
    check("rst_read_data", if1.read_data, 32'd0);
    check("rst_addr_err", {31'd0, if1.addr_err}, 32'd0);
    check("rst_l4_req_ready", {31'd0, if4.req_ready}, 32'd0);
    rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, if1.req_ready}, 32'd1);

    // name, op, rd, wr, addr, wdata, expected read_data, expected addr_err
    add("sw_00",   6'h2B, 1'b0, 1'b1, 32'h000, 32'h0BADF00D, 32'h0, 1'b0);
    add("sw_10",   6'h2B, 1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    add("lw_10",   6'h23, 1'b1, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
    add("sw_20",   6'h2B, 1'b0, 1'b1, 32'h020, 32'h11223344, 32'h0, 1'b0);
    add("sb_21",   6'h28, 1'b0, 1'b1, 32'h021, 32'h000000FD, 32'h0, 1'b0);
    add("lw_20a",  6'h23, 1'b1, 1'b0, 32'h020, 32'h0,        32'h1122FD44, 1'b0);
    add("lb_21",   6'h20, 1'b1, 1'b0, 32'h021, 32'h0,        32'hFFFFFFFD, 1'b0);
    add("lbu_21",  6'h24, 1'b1, 1'b0, 32'h021, 32'h0,        32'h000000FD, 1'b0);
    add("sw_20b",  6'h2B, 1'b0, 1'b1, 32'h020, 32'h11223344, 32'h0, 1'b0);
    add("sh_22",   6'h29, 1'b0, 1'b1, 32'h022, 32'h00008001, 32'h0, 1'b0);
    add("lw_20b",  6'h23, 1'b1, 1'b0, 32'h020, 32'h0,        32'h80013344, 1'b0);
    add("lh_22",   6'h21, 1'b1, 1'b0, 32'h022, 32'h0,        32'hFFFF8001, 1'b0);
    add("lhu_22",  6'h25, 1'b1, 1'b0, 32'h022, 32'h0,        32'h00008001, 1'b0);
    add("sb_23",   6'h28, 1'b0, 1'b1, 32'h023, 32'h0000007F, 32'h0, 1'b0);
    add("lb_23",   6'h20, 1'b1, 1'b0, 32'h023, 32'h0,        32'h0000007F, 1'b0);
    add("lh_20",   6'h21, 1'b1, 1'b0, 32'h020, 32'h0,        32'h00003344, 1'b0);
    add("sw_3fc",  6'h2B, 1'b0, 1'b1, 32'h3FC, 32'h55AA55AA, 32'h0, 1'b0);
    add("lw_3fc",  6'h23, 1'b1, 1'b0, 32'h3FC, 32'h0,        32'h55AA55AA, 1'b0);
    add("lw_oor",  6'h23, 1'b1, 1'b0, 32'h400, 32'h0,        32'h0, 1'b1);
    add("sw_oor",  6'h2B, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1);
    add("lw_00",   6'h23, 1'b1, 1'b0, 32'h000, 32'h0,        32'h0BADF00D, 1'b0);
    add("rdwr",    6'h2B, 1'b1, 1'b1, 32'h010, 32'h12345678, 32'h0, 1'b1);
    add("lw_10b",  6'h23, 1'b1, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
    add("nop",     6'h23, 1'b0, 1'b0, 32'h010, 32'h0,        32'h0, 1'b0);
    add("nop_oor", 6'h23, 1'b0, 1'b0, 32'h800, 32'h0,        32'h0, 1'b0);
    add("lh_23",   6'h21, 1'b1, 1'b0, 32'h023, 32'h0,        ALIGN ? 32'h0 : 32'h00007F01, ALIGN);
    add("sw_13",   6'h2B, 1'b0, 1'b1, 32'h013, 32'hCAFEF00D, 32'h0, ALIGN);
    add("lw_10c",  6'h23, 1'b1, 1'b0, 32'h010, 32'h0,        ALIGN ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0);
    add("lw_12",   6'h23, 1'b1, 1'b0, 32'h012, 32'h0,        ALIGN ? 32'h0 : 32'hCAFEF00D, ALIGN);

    foreach (vq[i]) begin
      xact1(vq[i].op, vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wd, rdata, err, lat);
      $display("L1 %-8s op=%02h rd=%0d wr=%0d addr=%08h wd=%08h -> data=%08h err=%0d lat=%0d",
               vq[i].name, vq[i].op, vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wd, rdata, err, lat);
      check({vq[i].name, "_data"}, rdata, vq[i].exp_d);
      check({vq[i].name, "_err"}, {31'd0, err}, {31'd0, vq[i].exp_e});
      check({vq[i].name, "_lat"}, 32'(lat), 32'd1);
      @(negedge clk);
      check({vq[i].name, "_pulse"}, {31'd0, if1.resp_valid}, 32'd0);
    end

    // LATENCY=4: sw accepted at cycle 0, lw held from cycle 1 and accepted at cycle 5.
    @(negedge clk);
    check("l4_ready_c0", {31'd0, if4.req_ready}, 32'd1);
    if4.req_valid = 1'b1; if4.opcode = 6'h2B; if4.MemRead = 1'b0; if4.MemWrite = 1'b1;
    if4.address = 32'h40; if4.write_data = 32'h01020304;
    @(posedge clk);
    #1;
    if4.opcode = 6'h23; if4.MemRead = 1'b1; if4.MemWrite = 1'b0; if4.write_data = 32'hFFFFFFFF;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("l4_ready_c%0d", c), {31'd0, if4.req_ready}, (c == 5) ? 32'd1 : 32'd0);
      check($sformatf("l4_resp_c%0d", c), {31'd0, if4.resp_valid},
            (c == 4 || c == 9) ? 32'd1 : 32'd0);
      if (c == 4) begin
        check("l4_sw_err", {31'd0, if4.addr_err}, 32'd0);
        $display("L4 sw addr=00000040 wd=01020304 -> resp cycle %0d err=%0d", c, if4.addr_err);
      end
      if (c == 9) begin
        check("l4_lw_data", if4.read_data, 32'h01020304);
        check("l4_lw_err", {31'd0, if4.addr_err}, 32'd0);
        $display("L4 lw addr=00000040 -> resp cycle %0d data=%08h err=%0d",
                 c, if4.read_data, if4.addr_err);
      end
      if (c == 6) if4.req_valid = 1'b0;
    end

    // LATENCY=3: establish an old value, then reset during the next store's WAIT.
    @(negedge clk);
    if3.req_valid = 1'b1; if3.opcode = 6'h2B; if3.MemRead = 1'b0; if3.MemWrite = 1'b1;
    if3.address = 32'h30; if3.write_data = 32'h12345678;
    @(posedge clk);
    #1;
    if3.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if3.resp_valid && n < 20);
    $display("L3 sw addr=00000030 wd=12345678 -> lat=%0d err=%0d", n, if3.addr_err);
    check("l3_sw_lat", 32'(n), 32'd3);

    @(negedge clk);
    @(negedge clk);
    if3.req_valid = 1'b1; if3.write_data = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    if3.req_valid = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    check("l3_rst_req_ready", {31'd0, if3.req_ready}, 32'd0);
    check("l3_rst_resp_valid", {31'd0, if3.resp_valid}, 32'd0);
    check("l3_rst_read_data", if3.read_data, 32'd0);
    check("l3_rst_addr_err", {31'd0, if3.addr_err}, 32'd0);
    rst3 = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if3.resp_valid) saw = 1'b1;
    end
    $display("L3 sw addr=00000030 wd=AAAAAAAA reset mid-op -> resp_seen=%0d", saw);
    check("l3_no_resp", {31'd0, saw}, 32'd0);

    if3.req_valid = 1'b1; if3.opcode = 6'h23; if3.MemRead = 1'b1; if3.MemWrite = 1'b0;
    @(posedge clk);
    #1;
    if3.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if3.resp_valid && n < 20);
    $display("L3 lw addr=00000030 -> data=%08h err=%0d lat=%0d", if3.read_data, if3.addr_err, n);
    check("l3_lw_lat", 32'(n), 32'd3);
    check("l3_lw_data", if3.read_data, 32'h12345678);
    check("l3_lw_err", {31'd0, if3.addr_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
